// File: rtl/instr_fetch_unit.sv
// Handshaked multicycle instruction fetch: assembles a 32-bit word from BUSBYTES-wide beats.
// Optional feature macro: MISALIGN_TRAP_EN (trap unaligned fetch addresses instead of fetching).
module ifu_lane #(
  parameter int BW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [BW-1:0] d,
  output logic [BW-1:0] q
);
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)  q <= '0;
    else if (en) q <= d;
  end
endmodule

module instr_fetch_unit #(
  parameter int WIDTH    = 8,
  parameter int BUSBYTES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  pc_ld,
  input  logic [WIDTH-1:0]      pc_ld_val,
  output logic                  mem_req,
  output logic [WIDTH-1:0]      mem_adr,
  input  logic                  mem_ready,
  input  logic [8*BUSBYTES-1:0] mem_rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  misalign,
  output logic [31:0]           instr,
  output logic [WIDTH-1:0]      pc
);
  localparam int NBEATS = 4 / BUSBYTES;
  localparam int BW     = 8 * BUSBYTES;
  localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

  typedef struct packed {
    logic             req;
    logic [WIDTH-1:0] adr;
  } beat_req_t;

  typedef struct packed {
    logic          ready;
    logic [BW-1:0] data;
  } beat_rsp_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t                        state, state_nxt;
  logic [BEAT_W-1:0]             beat, beat_nxt;
  logic [WIDTH-1:0]              fadr, fadr_nxt;
  logic [WIDTH-1:0]              pc_nxt;
  logic [WIDTH-1:0]              sel_adr;
  logic [WIDTH-1:0]              adr_off;
  logic                          cap_en;
  logic                          last_beat;
  logic                          trap;
  logic [NBEATS-1:0][BW-1:0]     lane_q;
  beat_req_t                     breq;
  beat_rsp_t                     brsp;

  assign sel_adr   = pc_ld ? pc_ld_val : pc;
  assign last_beat = (beat == BEAT_W'(NBEATS - 1));
  assign adr_off   = WIDTH'(int'(beat) * BUSBYTES);

  // Request is combinational from state so an async reset drops it immediately.
  assign breq.req  = (state == S_REQ);
  assign breq.adr  = breq.req ? (fadr + adr_off) : '0;
  assign brsp.ready = mem_ready;
  assign brsp.data  = mem_rdata;

  assign mem_req = breq.req;
  assign mem_adr = breq.adr;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_DONE);
  assign instr   = lane_q;

`ifdef MISALIGN_TRAP_EN
  logic mis_q;
  assign trap = (sel_adr[1:0] != 2'b00);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) mis_q <= 1'b0;
    else        mis_q <= (state == S_IDLE) && start && trap;
  end

  assign misalign = mis_q && (state == S_DONE);
`else
  assign trap     = 1'b0;
  assign misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      beat  <= '0;
      fadr  <= '0;
      pc    <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
      fadr  <= fadr_nxt;
      pc    <= pc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    fadr_nxt  = fadr;
    pc_nxt    = pc;
    cap_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (pc_ld) pc_nxt = pc_ld_val;
        if (start) begin
          fadr_nxt  = sel_adr;
          beat_nxt  = '0;
          // A trapped fetch skips memory entirely and reports through DONE.
          state_nxt = trap ? S_DONE : S_REQ;
        end
      end
      S_REQ: begin
        if (brsp.ready) begin
          cap_en = 1'b1;
          if (last_beat) begin
            pc_nxt    = fadr + WIDTH'(4);
            state_nxt = S_DONE;
          end else begin
            beat_nxt = beat + BEAT_W'(1);
          end
        end
      end
      S_DONE: begin
        if (pc_ld) pc_nxt = pc_ld_val;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // One capture register per beat position; little-endian beat placement.
  for (genvar g = 0; g < NBEATS; g++) begin : g_lane
    ifu_lane #(.BW(BW)) u_lane (
      .clk   (clk),
      .reset (reset),
      .en    (cap_en && (beat == BEAT_W'(g))),
      .d     (brsp.data),
      .q     (lane_q[g])
    );
  end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: one byte-wide and one word-wide instance vs a byte-memory model.
module tb_instr_fetch_unit;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start_s[2], pc_ld_s[2], mem_ready_s[2];
  logic [7:0]  ldv_s[2];
  logic [7:0]  rdata1;
  logic [31:0] rdata4;
  logic        mem_req_s[2], busy_s[2], done_s[2], mis_s[2];
  logic [7:0]  adr_s[2], pc_s[2];
  logic [31:0] instr_s[2];

  int checks = 0;
  int errors = 0;
  logic [7:0]  mem[2][256];
  logic [7:0]  m_pc[2];
  logic [31:0] m_instr[2];
  int nb[2] = '{4, 1};
  int bb[2] = '{1, 4};

  instr_fetch_unit #(.WIDTH(8), .BUSBYTES(1)) u1 (
    .clk(clk), .reset(reset), .start(start_s[0]), .pc_ld(pc_ld_s[0]), .pc_ld_val(ldv_s[0]),
    .mem_req(mem_req_s[0]), .mem_adr(adr_s[0]), .mem_ready(mem_ready_s[0]), .mem_rdata(rdata1),
    .busy(busy_s[0]), .done(done_s[0]), .misalign(mis_s[0]), .instr(instr_s[0]), .pc(pc_s[0]));

  instr_fetch_unit #(.WIDTH(8), .BUSBYTES(4)) u4 (
    .clk(clk), .reset(reset), .start(start_s[1]), .pc_ld(pc_ld_s[1]), .pc_ld_val(ldv_s[1]),
    .mem_req(mem_req_s[1]), .mem_adr(adr_s[1]), .mem_ready(mem_ready_s[1]), .mem_rdata(rdata4),
    .busy(busy_s[1]), .done(done_s[1]), .misalign(mis_s[1]), .instr(instr_s[1]), .pc(pc_s[1]));

  function automatic logic [31:0] word_at(input int u, input logic [7:0] a);
    return {mem[u][8'(a + 8'd3)], mem[u][8'(a + 8'd2)], mem[u][8'(a + 8'd1)], mem[u][a]};
  endfunction

  task automatic drive_data(input int u, input bit valid, input logic [7:0] a);
    if (u == 0) rdata1 = valid ? mem[0][a] : 8'($urandom);
    else        rdata4 = valid ? word_at(1, a) : $urandom;
  endtask

  // One full fetch; wbeat/wn force wn wait cycles on beat wbeat, others get 0..maxrand waits.
  task automatic fetch(input int u, input bit ld, input logic [7:0] ldv, input int wbeat,
                       input int wn, input int maxrand, input bit noise, input bit dld,
                       input logic [7:0] dldv);
    logic [7:0] fadr, ea;
    int waits;
    bit trap;
    fadr = ld ? ldv : m_pc[u];
    trap = 1'b0;
`ifdef MISALIGN_TRAP_EN
    trap = (fadr[1:0] != 2'b00);
`endif
    start_s[u] = 1'b1; pc_ld_s[u] = ld; ldv_s[u] = ldv;
    if (ld) m_pc[u] = ldv;
    @(posedge clk); @(negedge clk);
    start_s[u] = 1'b0; pc_ld_s[u] = 1'b0;
    if (!trap) begin
      for (int b = 0; b < nb[u]; b++) begin
        ea = 8'(fadr + 8'(b * bb[u]));
        waits = (b == wbeat) ? wn : ((maxrand > 0) ? $urandom_range(0, maxrand) : 0);
        for (int w = 0; w <= waits; w++) begin
          checks++;
          if (mem_req_s[u] !== 1'b1 || adr_s[u] !== ea || done_s[u] !== 1'b0 || busy_s[u] !== 1'b1) begin
            errors++;
            $display("FAIL beat u%0d b%0d w%0d: req=%b adr=%h done=%b busy=%b, want req=1 adr=%h done=0 busy=1",
                     u, b, w, mem_req_s[u], adr_s[u], done_s[u], busy_s[u], ea);
          end
          if (noise) begin
            start_s[u] = 1'($urandom_range(0, 1));
            pc_ld_s[u] = 1'($urandom_range(0, 1));
            ldv_s[u]   = 8'($urandom);
          end
          mem_ready_s[u] = (w == waits);
          drive_data(u, w == waits, ea);
          @(posedge clk); @(negedge clk);
        end
      end
      mem_ready_s[u] = 1'b0; start_s[u] = 1'b0; pc_ld_s[u] = 1'b0;
      m_instr[u] = word_at(u, fadr);
      m_pc[u]    = 8'(fadr + 8'd4);
    end
    checks++;
    if (done_s[u] !== 1'b1 || mis_s[u] !== trap || mem_req_s[u] !== 1'b0 || busy_s[u] !== 1'b1 ||
        instr_s[u] !== m_instr[u] || pc_s[u] !== m_pc[u]) begin
      errors++;
      $display("FAIL done u%0d fadr=%h: done=%b mis=%b req=%b busy=%b instr=%h pc=%h, want 1 %b 0 1 %h %h",
               u, fadr, done_s[u], mis_s[u], mem_req_s[u], busy_s[u], instr_s[u], pc_s[u],
               trap, m_instr[u], m_pc[u]);
    end
    start_s[u] = noise; pc_ld_s[u] = dld; ldv_s[u] = dldv;
    if (dld) m_pc[u] = dldv;
    @(posedge clk); @(negedge clk);
    start_s[u] = 1'b0; pc_ld_s[u] = 1'b0;
    checks++;
    if (done_s[u] !== 1'b0 || busy_s[u] !== 1'b0 || mis_s[u] !== 1'b0 || mem_req_s[u] !== 1'b0 ||
        pc_s[u] !== m_pc[u] || instr_s[u] !== m_instr[u]) begin
      errors++;
      $display("FAIL idle-after u%0d: done=%b busy=%b mis=%b req=%b pc=%h instr=%h, want 0 0 0 0 %h %h",
               u, done_s[u], busy_s[u], mis_s[u], mem_req_s[u], pc_s[u], instr_s[u], m_pc[u], m_instr[u]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (mem_req_s[u] !== 1'b0 || busy_s[u] !== 1'b0 || done_s[u] !== 1'b0 || mis_s[u] !== 1'b0 ||
          adr_s[u] !== 8'h00 || pc_s[u] !== 8'h00 || instr_s[u] !== 32'h0) begin
        errors++;
        $display("FAIL %s u%0d: req=%b busy=%b done=%b mis=%b adr=%h pc=%h instr=%h, want all zero",
                 tag, u, mem_req_s[u], busy_s[u], done_s[u], mis_s[u], adr_s[u], pc_s[u], instr_s[u]);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    reset = 1'b1;
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin m_pc[u] = 8'h00; m_instr[u] = 32'h0; end
  endtask

  task automatic test_spec_vectors();
    mem[0][0] = 8'h20; mem[0][1] = 8'h07; mem[0][2] = 8'h02; mem[0][3] = 8'h80;
    fetch(0, 1'b0, 8'h00, -1, 0, 0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (instr_s[0] !== 32'h80020720 || pc_s[0] !== 8'h04) begin
      errors++; $display("FAIL vec1: instr=%h pc=%h, want 80020720 04", instr_s[0], pc_s[0]);
    end
    mem[1][8'h10] = 8'h44; mem[1][8'h11] = 8'h00; mem[1][8'h12] = 8'h07; mem[1][8'h13] = 8'hAC;
    fetch(1, 1'b1, 8'h10, -1, 0, 0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (instr_s[1] !== 32'hAC070044 || pc_s[1] !== 8'h14) begin
      errors++; $display("FAIL vec2: instr=%h pc=%h, want ac070044 14", instr_s[1], pc_s[1]);
    end
    fetch(0, 1'b1, 8'h00, 2, 3, 0, 1'b0, 1'b0, 8'h00);
    fetch(0, 1'b1, 8'h3C, -1, 0, 0, 1'b0, 1'b0, 8'h00);
    checks++;
    if (pc_s[0] !== 8'h40) begin
      errors++; $display("FAIL vec4 pc: pc=%h, want 40", pc_s[0]);
    end
  endtask

  task automatic test_wrap();
    fetch(0, 1'b1, 8'hFC, -1, 0, 1, 1'b0, 1'b0, 8'h00);
    checks++;
    if (pc_s[0] !== 8'h00) begin
      errors++; $display("FAIL wrap pc: pc=%h, want 00", pc_s[0]);
    end
    fetch(0, 1'b1, 8'hFE, -1, 0, 0, 1'b0, 1'b0, 8'h00);
    fetch(1, 1'b1, 8'hFC, -1, 0, 2, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_misalign();
    fetch(0, 1'b1, 8'h05, -1, 0, 0, 1'b0, 1'b0, 8'h00);
    fetch(1, 1'b1, 8'h05, -1, 0, 0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_done_pcld();
    fetch(0, 1'b0, 8'h00, -1, 0, 1, 1'b0, 1'b1, 8'h80);
    fetch(0, 1'b0, 8'h00, -1, 0, 1, 1'b0, 1'b0, 8'h00);
    fetch(1, 1'b0, 8'h00, -1, 0, 1, 1'b0, 1'b1, 8'h40);
    fetch(1, 1'b0, 8'h00, -1, 0, 1, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_ignored_ready();
    for (int u = 0; u < 2; u++) begin
      mem_ready_s[u] = 1'b1;
      drive_data(u, 1'b0, 8'h00);
      repeat (2) @(posedge clk);
      @(negedge clk);
      mem_ready_s[u] = 1'b0;
      checks++;
      if (instr_s[u] !== m_instr[u] || busy_s[u] !== 1'b0 || mem_req_s[u] !== 1'b0) begin
        errors++;
        $display("FAIL idle-ready u%0d: instr=%h busy=%b req=%b, want %h 0 0",
                 u, instr_s[u], busy_s[u], mem_req_s[u], m_instr[u]);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] fadr;
    fadr = 8'h24;
    start_s[0] = 1'b1; pc_ld_s[0] = 1'b1; ldv_s[0] = fadr;
    @(posedge clk); @(negedge clk);
    start_s[0] = 1'b0; pc_ld_s[0] = 1'b0;
    for (int b = 0; b < 2; b++) begin
      mem_ready_s[0] = 1'b1;
      drive_data(0, 1'b1, 8'(fadr + 8'(b)));
      @(posedge clk); @(negedge clk);
    end
    mem_ready_s[0] = 1'b0;
    checks++;
    if (mem_req_s[0] !== 1'b1 || adr_s[0] !== 8'(fadr + 8'd2)) begin
      errors++; $display("FAIL pre-reset beat2: req=%b adr=%h, want 1 %h", mem_req_s[0], adr_s[0], 8'(fadr + 8'd2));
    end
    reset = 1'b0;
    #1;
    check_reset_state("mid-reset");
    @(negedge clk);
    reset = 1'b1;
    for (int u = 0; u < 2; u++) begin m_pc[u] = 8'h00; m_instr[u] = 32'h0; end
    @(negedge clk);
    fetch(0, 1'b0, 8'h00, -1, 0, 0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      fetch($urandom_range(0, 1), 1'($urandom_range(0, 1)), 8'($urandom), -1, 0, 3, 1'b1,
            1'($urandom_range(0, 1)), 8'($urandom));
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      start_s[u] = 1'b0; pc_ld_s[u] = 1'b0; mem_ready_s[u] = 1'b0; ldv_s[u] = 8'h00;
      for (int a = 0; a < 256; a++) mem[u][a] = 8'($urandom);
    end
    rdata1 = 8'h00; rdata4 = 32'h0;
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_spec_vectors();
    test_wrap();
    test_misalign();
    test_done_pcld();
    test_ignored_ready();
    test_mid_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
